wash_phase_timer: RTL and testbench



---
 rtl/wash_phase_timer.sv | 173 +++++++++++++++++
 tb/tb_wash_phase_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_phase_timer.sv
// ---------------------------------------------------------------------------
// wash_phase_timer
//
// Purpose:
//   Phase-duration timer for the washing machine controller. It derives a
//   one-second period from the system clock, scaled by the clock-rate select
//   captured at start. It loads the duration of the requested phase and counts
//   it down one second at a time. Pause freezes the countdown and abort
//   cancels it. A one-cycle expired pulse tells the controller to advance to
//   the next phase.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   clk_freq   in   2  clock rate select (00=1x, 01=2x, 10=4x, 11=8x BASE_CYCLES)
//   start      in   1  load-and-run request; honoured only when idle
//   phase_sel  in   2  phase to time (00=fill, 01=wash, 10=rinse, 11=spin)
//   pause      in   1  level; freezes prescaler and remaining while high
//   abort      in   1  cancels the running phase; beats start and expiry
//   busy       out  1  timer loaded and not yet expired or aborted
//   paused     out  1  busy and frozen by pause
//   sec_tick   out  1  one-cycle pulse per elapsed second
//   expired    out  1  one-cycle pulse when the phase completes
//   remaining  out  9  seconds left in the current phase
// ---------------------------------------------------------------------------
module wash_phase_timer #(
    parameter int unsigned BASE_CYCLES = 1000000,
    parameter int unsigned FILL_SEC    = 60,
    parameter int unsigned WASH_SEC    = 300,
    parameter int unsigned RINSE_SEC   = 120,
    parameter int unsigned SPIN_SEC    = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] clk_freq,
    input  logic       start,
    input  logic [1:0] phase_sel,
    input  logic       pause,
    input  logic       abort,
    output logic       busy,
    output logic       paused,
    output logic       sec_tick,
    output logic       expired,
    output logic [8:0] remaining
);

    // Durations must fit the 9-bit counter and be non-zero; the largest
    // seconds period (8x BASE_CYCLES) must fit the 32-bit prescaler.
    if (FILL_SEC < 1 || FILL_SEC > 511) begin : g_bad_fill
        $error("FILL_SEC must be in 1..511");
    end
    if (WASH_SEC < 1 || WASH_SEC > 511) begin : g_bad_wash
        $error("WASH_SEC must be in 1..511");
    end
    if (RINSE_SEC < 1 || RINSE_SEC > 511) begin : g_bad_rinse
        $error("RINSE_SEC must be in 1..511");
    end
    if (SPIN_SEC < 1 || SPIN_SEC > 511) begin : g_bad_spin
        $error("SPIN_SEC must be in 1..511");
    end
    if (BASE_CYCLES < 1 || (64'(BASE_CYCLES) << 3) > 64'hFFFF_FFFF) begin : g_bad_base
        $error("BASE_CYCLES out of range for a 32-bit prescaler");
    end

    localparam logic [31:0] BASE_32  = 32'(BASE_CYCLES);
    localparam logic [8:0]  FILL_D   = 9'(FILL_SEC);
    localparam logic [8:0]  WASH_D   = 9'(WASH_SEC);
    localparam logic [8:0]  RINSE_D  = 9'(RINSE_SEC);
    localparam logic [8:0]  SPIN_D   = 9'(SPIN_SEC);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] prescaler;
    logic [1:0]  freq_q;
    logic [31:0] period;
    logic [8:0]  load_value;

    // Seconds period follows the rate captured at start, so clk_freq changes
    // mid-phase cannot stretch or shrink the running second.
    always_comb begin
        period = BASE_32 << freq_q;
    end

    always_comb begin
        case (phase_sel)
            2'b00:   load_value = FILL_D;
            2'b01:   load_value = WASH_D;
            2'b10:   load_value = RINSE_D;
            default: load_value = SPIN_D;
        endcase
    end

    // Single FSM with registered outputs. Abort is checked before anything
    // else so it beats both a same-cycle start and a same-cycle expiry. Any
    // busy cycle with pause low counts (including the HOLD->RUN return cycle),
    // so expiry slips by exactly the number of cycles pause was high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            paused    <= 1'b0;
            sec_tick  <= 1'b0;
            expired   <= 1'b0;
            remaining <= 9'd0;
            prescaler <= 32'd0;
            freq_q    <= 2'b00;
        end else begin
            sec_tick <= 1'b0;
            expired  <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                paused    <= 1'b0;
                remaining <= 9'd0;
                prescaler <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            remaining <= load_value;
                            prescaler <= 32'd0;
                            freq_q    <= clk_freq;
                            busy      <= 1'b1;
                            if (pause) begin
                                state  <= HOLD;
                                paused <= 1'b1;
                            end else begin
                                state  <= RUN;
                                paused <= 1'b0;
                            end
                        end
                    end
                    RUN, HOLD: begin
                        if (pause) begin
                            state  <= HOLD;
                            paused <= 1'b1;
                        end else begin
                            state  <= RUN;
                            paused <= 1'b0;
                            if (prescaler == period - 32'd1) begin
                                prescaler <= 32'd0;
                                remaining <= remaining - 9'd1;
                                sec_tick  <= 1'b1;
                                // Final second: report expiry alongside the
                                // last tick and drop busy in the same cycle.
                                if (remaining == 9'd1) begin
                                    expired <= 1'b1;
                                    state   <= IDLE;
                                    busy    <= 1'b0;
                                end
                            end else begin
                                prescaler <= prescaler + 32'd1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        paused    <= 1'b0;
                        remaining <= 9'd0;
                        prescaler <= 32'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wash_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_wash_phase_timer
//
// Purpose:
//   Self-checking bench for wash_phase_timer. A behavioural model tracks the
//   number of counted cycles since start and derives remaining, sec_tick and
//   expired from it arithmetically. Directed scenarios are followed by a
//   randomized phase.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_wash_phase_timer;

    localparam int BASE  = 4;
    localparam int FILL  = 2;
    localparam int WASH  = 5;
    localparam int RINSE = 3;
    localparam int SPIN  = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] clk_freq;
    logic       start;
    logic [1:0] phase_sel;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       paused;
    logic       sec_tick;
    logic       expired;
    logic [8:0] remaining;

    wash_phase_timer #(
        .BASE_CYCLES(BASE),
        .FILL_SEC   (FILL),
        .WASH_SEC   (WASH),
        .RINSE_SEC  (RINSE),
        .SPIN_SEC   (SPIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_freq (clk_freq),
        .start    (start),
        .phase_sel(phase_sel),
        .pause    (pause),
        .abort    (abort),
        .busy     (busy),
        .paused   (paused),
        .sec_tick (sec_tick),
        .expired  (expired),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: whether a phase is active, its length in seconds and
    // cycles-per-second, and how many cycles have actually counted so far.
    bit m_busy   = 1'b0;
    bit m_paused = 1'b0;
    bit m_tick   = 1'b0;
    bit m_exp    = 1'b0;
    int m_rem    = 0;
    int m_n      = 0;
    int m_p      = 1;
    int m_active = 0;

    int cyc          = 0;
    int last_exp_cyc = -1;
    int exp_count    = 0;
    int tick_count   = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
        end
    endtask

    function automatic int duration(input logic [1:0] sel);
        case (sel)
            2'b00:   return FILL;
            2'b01:   return WASH;
            2'b10:   return RINSE;
            default: return SPIN;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic modelEdge();
        m_tick = 1'b0;
        m_exp  = 1'b0;
        if (!rst_n || abort) begin
            m_busy   = 1'b0;
            m_paused = 1'b0;
            m_rem    = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy   = 1'b1;
                m_paused = pause;
                m_n      = duration(phase_sel);
                m_p      = BASE * (1 << clk_freq);
                m_active = 0;
                m_rem    = m_n;
            end
        end else begin
            m_paused = pause;
            if (!pause) begin
                m_active++;
                if (m_active % m_p == 0) begin
                    m_tick = 1'b1;
                    m_rem  = m_n - m_active / m_p;
                    if (m_active == m_n * m_p) begin
                        m_exp    = 1'b1;
                        m_busy   = 1'b0;
                        m_paused = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            modelEdge();
            cyc++;
            #1;
            if (expired === 1'b1) begin
                last_exp_cyc = cyc;
                exp_count++;
            end
            if (sec_tick === 1'b1) tick_count++;
            checkOutput("busy",      int'(busy),      int'(m_busy));
            checkOutput("paused",    int'(paused),    int'(m_paused));
            checkOutput("sec_tick",  int'(sec_tick),  int'(m_tick));
            checkOutput("expired",   int'(expired),   int'(m_exp));
            checkOutput("remaining", int'(remaining), m_rem);
        end
    endtask

    int t0;

    initial begin
        rst_n     = 1'b0;
        clk_freq  = 2'b00;
        start     = 1'b1;
        phase_sel = 2'b00;
        pause     = 1'b0;
        abort     = 1'b0;

        // 1: reset held with start high, then idle until a real start
        applyStimulus(2);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_remaining", int'(remaining), 0);
        rst_n = 1'b1;
        start = 1'b0;
        applyStimulus(3);
        checkOutput("idle_after_rst", int'(busy), 0);

        // 2: fill at 1x, expiry 8 cycles after the capture edge
        start = 1'b1; phase_sel = 2'b00; clk_freq = 2'b00;
        applyStimulus(1);
        t0 = cyc; start = 1'b0; last_exp_cyc = -1;
        checkOutput("fill_load", int'(remaining), 2);
        applyStimulus(4);
        checkOutput("fill_first_dec", int'(remaining), 1);
        applyStimulus(6);
        checkOutput("fill_exp_time", last_exp_cyc - t0, 8);

        // 3: wash at 4x, clk_freq change mid-phase ignored
        start = 1'b1; phase_sel = 2'b01; clk_freq = 2'b10;
        applyStimulus(1);
        t0 = cyc; start = 1'b0; last_exp_cyc = -1; tick_count = 0;
        applyStimulus(19);
        clk_freq = 2'b00;
        applyStimulus(70);
        checkOutput("wash4x_exp_time", last_exp_cyc - t0, 80);
        checkOutput("wash4x_ticks", tick_count, 5);

        // 4: rinse with pause high for 10 edges starting at T0+6
        start = 1'b1; phase_sel = 2'b10;
        applyStimulus(1);
        t0 = cyc; start = 1'b0; last_exp_cyc = -1;
        applyStimulus(5);
        pause = 1'b1;
        applyStimulus(10);
        checkOutput("rinse_frozen", int'(remaining), 2);
        checkOutput("rinse_paused", int'(paused), 1);
        pause = 1'b0;
        applyStimulus(12);
        checkOutput("rinse_exp_time", last_exp_cyc - t0, 22);

        // 5: wash aborted at T0+9, then start masked by abort in IDLE
        start = 1'b1; phase_sel = 2'b01;
        applyStimulus(1);
        start = 1'b0; exp_count = 0;
        applyStimulus(8);
        abort = 1'b1;
        applyStimulus(1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_remaining", int'(remaining), 0);
        start = 1'b1;
        applyStimulus(2);
        checkOutput("abort_start_busy", int'(busy), 0);
        abort = 1'b0; start = 1'b0;
        applyStimulus(30);
        checkOutput("abort_no_exp", exp_count, 0);

        // 6: restart attempt ignored, then start straight into HOLD
        start = 1'b1; phase_sel = 2'b00;
        applyStimulus(1);
        t0 = cyc; start = 1'b0; last_exp_cyc = -1;
        applyStimulus(2);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(8);
        checkOutput("restart_exp_time", last_exp_cyc - t0, 8);
        start = 1'b1; pause = 1'b1;
        applyStimulus(1);
        start = 1'b0; tick_count = 0;
        checkOutput("hold_paused", int'(paused), 1);
        checkOutput("hold_remaining", int'(remaining), 2);
        applyStimulus(12);
        checkOutput("hold_no_ticks", tick_count, 0);
        pause = 1'b0;
        applyStimulus(10);

        // Randomized traffic: held pause runs, rare aborts and resets
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            phase_sel = 2'($urandom_range(0, 3));
            clk_freq  = 2'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 299) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            applyStimulus(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
